// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port async SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int P0 = 0;
    localparam int P1 = 1;

    localparam int DEF_ADDR_W = 17;
    localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select between the two requesters.
// Define SRAM_ARB_RR_EN for round-robin with a last-grant register; otherwise port 0 has fixed priority.
module sram_arb_pick
    import sram_arb_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
    input  logic       i_clk,
    input  logic       i_rstN,
    input  logic       i_take,
`endif
    input  logic [1:0] i_req,
    output logic       o_winner
);

`ifdef SRAM_ARB_RR_EN
    logic r_lastGrant;

    // Resetting to port 1 makes port 0 the winner of the first contention.
    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_lastGrant <= 1'b1;
        end else if (i_take) begin
            r_lastGrant <= o_winner;
        end
    end

    always_comb begin
        if (i_req[P0] && i_req[P1]) begin
            o_winner = ~r_lastGrant;
        end else begin
            o_winner = i_req[P1];
        end
    end
`else
    always_comb begin
        o_winner = ~i_req[P0] & i_req[P1];
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for a single async SRAM (active-low CE/OE/WE).
// Optional macro SRAM_ARB_RR_EN selects round-robin arbitration instead of fixed priority.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ACC_CYCLES = 2
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [1:0]            ack,
    output logic [DATA_W-1:0]     rdata,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_dout,
    output logic                  sram_dout_en,
    input  logic [DATA_W-1:0]     sram_din
);

    localparam logic [3:0] LAST_CNT = 4'(ACC_CYCLES - 1);

    state_t              r_state;
    state_t              w_stateNext;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cntNext;
    logic                r_winner;
    logic                r_isWrite;
    logic                w_pick;
    logic                w_take;
    logic                w_isWrite;
    logic [ADDR_W-1:0]   w_addrSel;
    logic [DATA_W-1:0]   w_dataSel;

    sram_arb_pick u_pick (
`ifdef SRAM_ARB_RR_EN
        .i_clk    (clk),
        .i_rstN   (rst_n),
        .i_take   (w_take),
`endif
        .i_req    (req),
        .o_winner (w_pick)
    );

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_take      = 1'b1;
                    w_stateNext = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_stateNext = ST_ACCESS;
                w_cntNext   = 4'd0;
            end
            ST_ACCESS: begin
                if (r_cnt == LAST_CNT) begin
                    w_stateNext = ST_DONE;
                end else begin
                    w_cntNext = r_cnt + 4'd1;
                end
            end
            ST_DONE: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Direction comes straight from the winner on the grant edge, from the latched copy afterwards.
    always_comb begin
        w_isWrite = r_isWrite;
        w_addrSel = w_pick ? addr[P1*ADDR_W +: ADDR_W] : addr[P0*ADDR_W +: ADDR_W];
        w_dataSel = w_pick ? wdata[P1*DATA_W +: DATA_W] : wdata[P0*DATA_W +: DATA_W];
        if (w_take) begin
            w_isWrite = we[w_pick];
        end
    end

    // Strobes are registered from the next state so the pins are glitch-free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_winner     <= 1'b0;
            r_isWrite    <= 1'b0;
            ack          <= 2'b00;
            rdata        <= '0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_addr    <= '0;
            sram_dout    <= '0;
            sram_dout_en <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_cnt        <= w_cntNext;
            r_isWrite    <= w_isWrite;
            if (w_take) begin
                r_winner  <= w_pick;
                sram_addr <= w_addrSel;
                sram_dout <= w_dataSel;
            end
            sram_ce_n    <= (w_stateNext == ST_IDLE);
            sram_oe_n    <= !((w_stateNext == ST_ACCESS) && !w_isWrite);
            sram_we_n    <= !((w_stateNext == ST_ACCESS) && w_isWrite);
            sram_dout_en <= (w_stateNext != ST_IDLE) && w_isWrite;
            ack          <= (w_stateNext == ST_DONE) ? (2'b01 << r_winner) : 2'b00;
            if ((r_state == ST_ACCESS) && (w_stateNext == ST_DONE) && !r_isWrite) begin
                rdata <= sram_din;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter (ACC_CYCLES=2) with a 128Kx16 SRAM model and an ack scoreboard.
// Define SRAM_ARB_RR_EN on both bench and RTL to check round-robin grant order.
module tb_sram_arbiter;

    localparam int AW = 17;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req = 2'b00;
    logic [1:0]        we = 2'b00;
    logic [2*AW-1:0]   addr = '0;
    logic [2*DW-1:0]   wdata = '0;
    logic [1:0]        ack;
    logic [DW-1:0]     rdata;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_dout;
    logic              sram_dout_en;
    logic [DW-1:0]     sram_din;

    logic [DW-1:0]     sramMem [0:(1<<AW)-1];
    logic [DW-1:0]     refMem  [0:(1<<AW)-1];

    typedef struct {
        logic          port;
        logic          isRead;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic          port;
        logic          isWrite;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] expRdata;
    } vec_t;

    exp_t sbQ[$];
    int   testsRun = 0;
    int   failures = 0;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYCLES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .ack          (ack),
        .rdata        (rdata),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .sram_addr    (sram_addr),
        .sram_dout    (sram_dout),
        .sram_dout_en (sram_dout_en),
        .sram_din     (sram_din)
    );

    always #5 clk = ~clk;

    // SRAM pin model
    assign sram_din = (!sram_ce_n && !sram_oe_n) ? sramMem[sram_addr] : 16'hFFFF;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dout_en) begin
            sramMem[sram_addr] <= sram_dout;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic port, input logic isWrite, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic [DW-1:0] expRd);
        exp_t e;
        we[port]             = isWrite;
        addr[port*AW +: AW]  = a;
        wdata[port*DW +: DW] = d;
        e.port   = port;
        e.isRead = !isWrite;
        e.data   = expRd;
        sbQ.push_back(e);
        if (isWrite) refMem[a] = d;
        req[port] = 1'b1;
    endtask

    task automatic runUntilAcks(input int nAcks, input bit dropOnAck, input string name);
        int seen = 0;
        int cyc  = 0;
        while (seen < nAcks && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ack != 2'b00) begin
                seen++;
                if (dropOnAck) req = req & ~ack;
            end
        end
        if (seen < nAcks) checkOutput({name, " ack timeout"}, seen, nAcks);
        if (!dropOnAck) req = 2'b00;
    endtask

    task automatic traceAccess(input logic port, input logic isWrite, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [DW-1:0] expRd,
                               output logic [5:0] ceT, output logic [5:0] weT, output logic [5:0] oeT,
                               output logic [5:0] denT, output logic [5:0] ackT,
                               output logic [AW-1:0] addrSeen, output logic [DW-1:0] doutSeen);
        addrSeen = '0;
        doutSeen = '0;
        @(negedge clk);
        applyStimulus(port, isWrite, a, d, expRd);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            ceT[i]  = sram_ce_n;
            weT[i]  = sram_we_n;
            oeT[i]  = sram_oe_n;
            denT[i] = sram_dout_en;
            ackT[i] = ack[port];
            if (i == 2) begin
                addrSeen = sram_addr;
                doutSeen = sram_dout;
            end
            if (ack[port]) req[port] = 1'b0;
        end
    endtask

    // Scoreboard and bus-safety monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ack != 2'b00) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected ack", {30'd0, ack}, 32'd0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("ack port", {30'd0, ack}, e.port ? 32'd2 : 32'd1);
                    if (e.isRead) checkOutput("rdata", {16'd0, rdata}, {16'd0, e.data});
                end
            end
            checkOutput("bus contention", {31'd0, (!sram_oe_n && sram_dout_en)}, 32'd0);
            checkOutput("two strobes low", {31'd0, (!sram_oe_n && !sram_we_n)}, 32'd0);
        end
    end

    initial begin
        vec_t          vecs[9];
        logic [5:0]    ceT, weT, oeT, denT, ackT;
        logic [AW-1:0] addrSeen;
        logic [DW-1:0] doutSeen;
        logic [1:0]    heldOrder[4];
        exp_t          e;
        int            cyc, n, t1, t2;
        logic          rp, rw;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;

        vecs[0] = '{1'b1, 1'b1, 17'h00010, 16'h5555, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 17'h00010, 16'h0000, 16'h5555};
        vecs[2] = '{1'b0, 1'b1, 17'h00005, 16'hBEEF, 16'h0000};
        vecs[3] = '{1'b0, 1'b0, 17'h00005, 16'h0000, 16'hBEEF};
        vecs[4] = '{1'b1, 1'b0, 17'h00010, 16'h0000, 16'h5555};
        vecs[5] = '{1'b0, 1'b0, 17'h00000, 16'h0000, 16'h0000};
        vecs[6] = '{1'b1, 1'b1, 17'h00010, 16'hA5A5, 16'h0000};
        vecs[7] = '{1'b1, 1'b0, 17'h00010, 16'h0000, 16'hA5A5};
        vecs[8] = '{1'b1, 1'b0, 17'h00005, 16'h0000, 16'hBEEF};

`ifdef SRAM_ARB_RR_EN
        heldOrder = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
        heldOrder = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif

        for (int i = 0; i < (1 << AW); i++) begin
            sramMem[i] = '0;
            refMem[i]  = '0;
        end

        repeat (3) @(negedge clk);
        checkOutput("reset ack", {30'd0, ack}, 32'd0);
        checkOutput("reset rdata", {16'd0, rdata}, 32'd0);
        checkOutput("reset ce_n", {31'd0, sram_ce_n}, 32'd1);
        checkOutput("reset oe_n", {31'd0, sram_oe_n}, 32'd1);
        checkOutput("reset we_n", {31'd0, sram_we_n}, 32'd1);
        checkOutput("reset sram_addr", {15'd0, sram_addr}, 32'd0);
        checkOutput("reset sram_dout", {16'd0, sram_dout}, 32'd0);
        checkOutput("reset dout_en", {31'd0, sram_dout_en}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cycle-exact write, then read back from the other port
        traceAccess(1'b0, 1'b1, 17'h00005, 16'h1234, 16'h0000, ceT, weT, oeT, denT, ackT, addrSeen, doutSeen);
        checkOutput("wr ce_n trace", {26'd0, ceT}, 32'b100001);
        checkOutput("wr we_n trace", {26'd0, weT}, 32'b110011);
        checkOutput("wr oe_n trace", {26'd0, oeT}, 32'b111111);
        checkOutput("wr dout_en trace", {26'd0, denT}, 32'b011110);
        checkOutput("wr ack0 trace", {26'd0, ackT}, 32'b010000);
        checkOutput("wr sram_addr", {15'd0, addrSeen}, 32'h00005);
        checkOutput("wr sram_dout", {16'd0, doutSeen}, 32'h1234);

        traceAccess(1'b1, 1'b0, 17'h00005, 16'h0000, 16'h1234, ceT, weT, oeT, denT, ackT, addrSeen, doutSeen);
        checkOutput("rd ce_n trace", {26'd0, ceT}, 32'b100001);
        checkOutput("rd we_n trace", {26'd0, weT}, 32'b111111);
        checkOutput("rd oe_n trace", {26'd0, oeT}, 32'b110011);
        checkOutput("rd dout_en trace", {26'd0, denT}, 32'b000000);
        checkOutput("rd ack1 trace", {26'd0, ackT}, 32'b010000);
        checkOutput("rd sram_addr", {15'd0, addrSeen}, 32'h00005);
        checkOutput("rd rdata", {16'd0, rdata}, 32'h1234);

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].port, vecs[i].isWrite, vecs[i].addr, vecs[i].wdata, vecs[i].expRdata);
            runUntilAcks(1, 1'b1, "vector");
        end

        // Simultaneous requests, each dropped on its own ack
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 17'h00040, 16'h1111, 16'h0000);
        applyStimulus(1'b1, 1'b1, 17'h00041, 16'h2222, 16'h0000);
        runUntilAcks(2, 1'b1, "pair");

        // Both ports hold req across four grants
        @(negedge clk);
        we = 2'b11;
        addr  = {17'h00043, 17'h00042};
        wdata = {16'h4343, 16'h4242};
        foreach (heldOrder[i]) begin
            e.port   = heldOrder[i][0];
            e.isRead = 1'b0;
            e.data   = '0;
            sbQ.push_back(e);
        end
        req = 2'b11;
        runUntilAcks(4, 1'b0, "held pair");

        // Reset in the middle of a write access
        @(negedge clk);
        we[0] = 1'b1;
        addr[0 +: AW]  = 17'h00020;
        wdata[0 +: DW] = 16'h7777;
        req[0] = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("pre-reset we_n", {31'd0, sram_we_n}, 32'd0);
        rst_n = 1'b0;
        req   = 2'b00;
        @(negedge clk);
        checkOutput("abort we_n", {31'd0, sram_we_n}, 32'd1);
        checkOutput("abort ce_n", {31'd0, sram_ce_n}, 32'd1);
        checkOutput("abort dout_en", {31'd0, sram_dout_en}, 32'd0);
        checkOutput("abort ack", {30'd0, ack}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post-reset ce_n", {31'd0, sram_ce_n}, 32'd1);
        checkOutput("post-reset ack", {30'd0, ack}, 32'd0);
        checkOutput("post-reset rdata", {16'd0, rdata}, 32'd0);

        // Held read at the top address: two back-to-back grants
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 17'h1FFFF, 16'hABCD, 16'h0000);
        runUntilAcks(1, 1'b1, "max write");
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 17'h1FFFF, 16'h0000, 16'hABCD);
        applyStimulus(1'b1, 1'b0, 17'h1FFFF, 16'h0000, 16'hABCD);
        cyc = 0; n = 0; t1 = -1; t2 = -1;
        while (n < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (ack[1]) begin
                if (n == 0) begin
                    t1 = cyc;
                    checkOutput("max sram_addr", {15'd0, sram_addr}, 32'h1FFFF);
                end else begin
                    t2 = cyc;
                end
                n++;
            end
        end
        req[1] = 1'b0;
        checkOutput("first read latency", t1, 4);
        checkOutput("back-to-back spacing", t2 - t1, 5);

        // Random traffic against the reference memory
        for (int i = 0; i < 60; i++) begin
            rp = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            ra = 17'h00100 + 17'($urandom_range(0, 15));
            rd = 16'($urandom);
            @(negedge clk);
            applyStimulus(rp, rw, ra, rd, rw ? 16'h0000 : refMem[ra]);
            runUntilAcks(1, 1'b1, "stress");
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", sbQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
